smem_result_packer: RTL

Drains finished SMEM results from the per-read mem array and streams them to the host as 512-bit cache lines. It sits directly downstream of the backward stage. It queues each `finish_sign` pulse (with its `read_num` and `mem_size`), reads that read's mem-array entries over a dedicated read port, and emits the results over a valid/ready stream:
- one optional header line per read;
- data lines carrying two 256-bit entries each.

---
 rtl/smem_result_packer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/smem_result_packer.sv
// Streams finished SMEM results from the per-read mem array as 512-bit lines.
// Optional per-read header line enabled by defining SMEM_RESULT_HEADER_EN.
module smem_result_packer #(
  parameter int READ_NUM_WIDTH = 10,
  parameter int FQ_DEPTH       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      finish_sign,
  input  logic [6:0]                mem_size,
  input  logic [READ_NUM_WIDTH-1:0] mem_size_read_num,
  output logic                      mem_rd_en,
  output logic [READ_NUM_WIDTH-1:0] mem_rd_read_num,
  output logic [6:0]                mem_rd_addr,
  input  logic [255:0]              mem_rd_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [511:0]              out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      fq_overflow
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int EW = READ_NUM_WIDTH + 7;
  localparam logic [AW:0] FQ_FULL = (AW+1)'(FQ_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {IDLE, HDR, RD_LO, RD_HI, CAP, SEND} state_t;

  logic [EW-1:0]             fq_mem [FQ_DEPTH];
  logic [AW-1:0]             fq_wr_ptr, fq_rd_ptr;
  logic [AW:0]               fq_count;
  logic                      fq_empty, fq_full, fq_push, fq_pop;
  logic [READ_NUM_WIDTH-1:0] head_read_num;
  logic [6:0]                head_size;

  state_t                    state;
  logic [5:0]                k;
  logic                      out_valid_r, out_last_r, mem_rd_en_r;
  logic                      hi_in_range, last_pair;

  logic [READ_NUM_WIDTH-1:0] cur_read_num;
  logic [6:0]                cur_size;
  logic [255:0]              lo_data;
  logic [511:0]              line_data;

`ifdef SMEM_RESULT_HEADER_EN
  function automatic logic [511:0] header_line(input logic [READ_NUM_WIDTH-1:0] rn,
                                               input logic [6:0] sz);
    header_line          = '0;
    header_line[31:0]    = 32'(rn);
    header_line[38:32]   = sz;
    header_line[63:48]   = 16'hA5E1;
  endfunction
`endif

  assign fq_empty = (fq_count == '0);
  assign fq_full  = (fq_count == FQ_FULL);
  assign {head_read_num, head_size} = fq_mem[fq_rd_ptr];

  // A read leaves the queue only when its final line is taken; reads with no
  // output at all are retired straight from IDLE.
`ifdef SMEM_RESULT_HEADER_EN
  assign fq_pop = out_valid_r && out_ready && out_last_r;
`else
  assign fq_pop = (out_valid_r && out_ready && out_last_r) ||
                  (state == IDLE && !fq_empty && head_size == 7'd0);
`endif
  assign fq_push = finish_sign && (!fq_full || fq_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fq_wr_ptr   <= '0;
      fq_rd_ptr   <= '0;
      fq_count    <= '0;
      fq_overflow <= 1'b0;
    end else begin
      if (fq_push) fq_wr_ptr <= fq_wr_ptr + AW'(1);
      if (fq_pop)  fq_rd_ptr <= fq_rd_ptr + AW'(1);
      case ({fq_push, fq_pop})
        2'b10:   fq_count <= fq_count + CNT_ONE;
        2'b01:   fq_count <= fq_count - CNT_ONE;
        default: ;
      endcase
      if (finish_sign && !fq_push) fq_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fq_push) fq_mem[fq_wr_ptr] <= {mem_size_read_num, mem_size};
  end

  assign hi_in_range = ({k, 1'b1} < cur_size);
  assign last_pair   = (({1'b0, k, 1'b0} + 8'd2) >= {1'b0, cur_size});

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      k           <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      mem_rd_en_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fq_empty) begin
            k <= '0;
`ifdef SMEM_RESULT_HEADER_EN
            state       <= HDR;
            out_valid_r <= 1'b1;
            out_last_r  <= (head_size == 7'd0);
`else
            if (head_size != 7'd0) begin
              state       <= RD_LO;
              mem_rd_en_r <= 1'b1;
            end
`endif
          end
        end
        HDR: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            if (cur_size == 7'd0) begin
              state <= IDLE;
            end else begin
              state       <= RD_LO;
              mem_rd_en_r <= 1'b1;
            end
          end
        end
        RD_LO: begin
          state       <= RD_HI;
          mem_rd_en_r <= hi_in_range;
        end
        RD_HI: begin
          state       <= CAP;
          mem_rd_en_r <= 1'b0;
        end
        CAP: begin
          state       <= SEND;
          out_valid_r <= 1'b1;
          out_last_r  <= last_pair;
        end
        SEND: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            if (out_last_r) begin
              state <= IDLE;
            end else begin
              k           <= k + 6'd1;
              state       <= RD_LO;
              mem_rd_en_r <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data capture: head latch in IDLE, low entry in RD_HI, line assembly in CAP
  always_ff @(posedge clk) begin
    if (state == IDLE && !fq_empty) begin
      cur_read_num <= head_read_num;
      cur_size     <= head_size;
`ifdef SMEM_RESULT_HEADER_EN
      line_data    <= header_line(head_read_num, head_size);
`endif
    end
    if (state == RD_HI) lo_data <= mem_rd_q;
    if (state == CAP)   line_data <= {(hi_in_range ? mem_rd_q : 256'd0), lo_data};
  end

  assign mem_rd_en       = mem_rd_en_r;
  assign mem_rd_addr     = mem_rd_en_r ? {k, (state == RD_HI)} : 7'd0;
  assign mem_rd_read_num = (state != IDLE) ? cur_read_num : '0;
  assign out_valid       = out_valid_r;
  assign out_last        = out_last_r;
  assign out_data        = out_valid_r ? line_data : '0;
  assign busy            = !fq_empty || (state != IDLE);

endmodule
